// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing one SD block-read controller between NREQ sector requesters.
// Define SD_ARB_BYTE_ADDR_EN for byte-addressed (SDSC) cards; the default build passes sector indices through.
module sd_sector_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int IDX_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*IDX_W-1:0]   req_sector,
  output logic [NREQ-1:0]         gnt,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  output logic [8:0]              rd_index,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err,
  input  logic                    sd_ready,
  output logic                    sd_read_en,
  output logic [31:0]             sd_address,
  input  logic [7:0]              sd_data,
  input  logic                    sd_data_ready
);

  // state  | meaning
  // ARB    | idle, pick next requester when the card is ready
  // ISSUE  | readEnable high until the controller drops ready
  // STREAM | forward 512 bytes to the owner
  // DRAIN  | wait for the controller to return to idle, then done
  // HALT   | watchdog fired, card state unknown, wait for reset
  typedef enum logic [2:0] {S_ARB, S_ISSUE, S_STREAM, S_DRAIN, S_HALT} state_t;

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  state_t           state, state_nxt;
  logic [OW-1:0]    rr_ptr, owner, pick_idx;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_sector;
  logic [31:0]      pick_addr;
  logic             pick_bad;
  logic [9:0]       byte_cnt;
  logic [WW-1:0]    wd_cnt;
  logic             wd_expired, wd_active;
  logic             do_grant, do_reject, do_byte, do_done, do_timeout;

  function automatic logic [OW-1:0] ptr_next(input logic [OW-1:0] p);
    if (int'(p) == NREQ - 1) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = OW'(idx);
      end
    end
  end

  assign pick_sector = req_sector[pick_idx*IDX_W +: IDX_W];

`ifdef SD_ARB_BYTE_ADDR_EN
  // SDSC cards take a byte address; indices past 4 GiB cannot be expressed.
  assign pick_addr = 32'(pick_sector) << 9;
  assign pick_bad  = (pick_sector >> 23) != '0;
`else
  assign pick_addr = 32'(pick_sector);
  assign pick_bad  = 1'b0;
`endif

  assign wd_expired = (wd_cnt == '0);
  assign wd_active  = (state == S_ISSUE) || (state == S_STREAM) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_reject  = 1'b0;
    do_byte    = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      S_ARB: begin
        if (sd_ready && pick_valid) begin
          if (pick_bad) begin
            do_reject = 1'b1;
          end else begin
            do_grant  = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (wd_expired) begin
          do_timeout = 1'b1;
          state_nxt  = S_HALT;
        end else if (!sd_ready) begin
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (wd_expired) begin
          do_timeout = 1'b1;
          state_nxt  = S_HALT;
        end else if (sd_data_ready && !byte_cnt[9]) begin
          do_byte = 1'b1;
          if (byte_cnt == 10'd511) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wd_expired) begin
          do_timeout = 1'b1;
          state_nxt  = S_HALT;
        end else if (sd_ready) begin
          do_done   = 1'b1;
          state_nxt = S_ARB;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt        <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_index   <= '0;
      done       <= '0;
      err        <= '0;
      sd_read_en <= 1'b0;
      sd_address <= '0;
      byte_cnt   <= '0;
      wd_cnt     <= '0;
    end else begin
      rd_valid   <= do_byte;
      done       <= '0;
      err        <= '0;
      sd_read_en <= (state_nxt == S_ISSUE);
      if (wd_active && !wd_expired) wd_cnt <= wd_cnt - 1'b1;
      if (do_grant) begin
        owner      <= pick_idx;
        gnt        <= NREQ'(1) << pick_idx;
        sd_address <= pick_addr;
        byte_cnt   <= '0;
        wd_cnt     <= WW'(TIMEOUT_CYC - 1);
      end
      if (do_reject) begin
        err    <= NREQ'(1) << pick_idx;
        rr_ptr <= ptr_next(pick_idx);
      end
      if (do_byte) begin
        rd_data  <= sd_data;
        rd_index <= byte_cnt[8:0];
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (do_done) begin
        done   <= gnt;
        rr_ptr <= ptr_next(owner);
        gnt    <= '0;
      end
      if (do_timeout) begin
        err <= gnt;
        gnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter: single sector, contention, request drop, reset mid-stream, watchdog.
module tb_sd_sector_arbiter;
  localparam int NREQ  = 2;
  localparam int IDX_W = 32;
  localparam int TMO   = 1000;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*IDX_W-1:0] req_sector;
  logic [NREQ-1:0]       gnt, done, err;
  logic [7:0]            rd_data, sd_data;
  logic                  rd_valid, sd_ready, sd_read_en, sd_data_ready;
  logic [8:0]            rd_index;
  logic [31:0]           sd_address;

  sd_sector_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_sector(req_sector), .gnt(gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index), .done(done), .err(err),
    .sd_ready(sd_ready), .sd_read_en(sd_read_en), .sd_address(sd_address),
    .sd_data(sd_data), .sd_data_ready(sd_data_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // controller model: bytes k&0xFF, optional stall point, optional surplus bytes
  int stall_at    = 100000;
  bit extra_bytes = 1'b0;
  bit mdl_abort   = 1'b0;

  initial begin
    sd_ready      = 1'b1;
    sd_data_ready = 1'b0;
    sd_data       = 8'h00;
    forever begin
      @(negedge clk);
      if (sd_read_en && sd_ready && !mdl_abort) begin
        repeat (2) @(negedge clk);
        sd_ready = 1'b0;
        while (sd_read_en && !mdl_abort) @(negedge clk);
        for (int k = 0; k < 512 + (extra_bytes ? 2 : 0) && !mdl_abort; k++) begin
          if (k == stall_at) begin
            sd_data_ready = 1'b0;
            while (!mdl_abort) @(negedge clk);
          end else begin
            sd_data       = 8'(k);
            sd_data_ready = 1'b1;
            @(negedge clk);
            sd_data_ready = 1'b0;
            if (k % 8 == 7) @(negedge clk);
          end
        end
        sd_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        sd_ready = 1'b1;
      end
    end
  end

  // monitor
  int cyc = 0;
  always @(posedge clk) cyc++;

  int nbytes, exp_idx, grant_cnt, grant_cyc, err_cyc, proto_bad;
  int done_cnt[NREQ];
  int err_cnt[NREQ];
  int grant_log[$];
  logic [31:0] addr_log[$];
  logic [31:0] grant_addr;
  logic [NREQ-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (gnt != '0 && prev_gnt == '0) begin
      nbytes = 0;
      exp_idx = 0;
      grant_cnt++;
      grant_cyc = cyc;
      grant_addr = sd_address;
      grant_log.push_back(gnt == 2'b10 ? 1 : 0);
      addr_log.push_back(sd_address);
    end
    if (gnt != '0 && sd_address !== grant_addr) proto_bad++;
    if (gnt != '0 && prev_gnt != '0 && gnt != prev_gnt) proto_bad++;
    if (!$onehot0(gnt)) proto_bad++;
    if ((done & err) != '0) proto_bad++;
    if (rd_valid) begin
      check("rd_index", 32'(rd_index), exp_idx);
      check("rd_data", 32'(rd_data), exp_idx & 32'hFF);
      exp_idx++;
      nbytes++;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (done[i]) done_cnt[i]++;
      if (err[i]) begin
        err_cnt[i]++;
        err_cyc = cyc;
      end
    end
    prev_gnt = gnt;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
  endtask

  task automatic wait_grant(input string tag);
    int start = grant_cnt;
    int n = 0;
    while (grant_cnt == start && n < 200) begin tick(1); n++; end
    check(tag, 32'(grant_cnt != start), 1);
  endtask

  task automatic wait_done(input string tag, input int idx);
    int start = done_cnt[idx];
    int n = 0;
    while (done_cnt[idx] == start && n < 1500) begin tick(1); n++; end
    check(tag, 32'(done_cnt[idx] != start), 1);
  endtask

  task automatic wait_bytes(input string tag, input int target);
    int n = 0;
    while (nbytes < target && n < 1500) begin tick(1); n++; end
    check(tag, 32'(nbytes >= target), 1);
  endtask

  task automatic wait_model_idle();
    int n = 0;
    mdl_abort = 1'b1;
    while (!sd_ready && n < 50) begin tick(1); n++; end
    check("model_idle", 32'(sd_ready), 1);
    mdl_abort = 1'b0;
  endtask

  initial begin
    int g0, d0, gc;
    reset = 1'b0;
    req = '0;
    req_sector = '0;
    tick(3);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_index", 32'(rd_index), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_read_en", 32'(sd_read_en), 0);
    check("rst_address", sd_address, 0);
    reset = 1'b1;

    // single sector, with two surplus bytes after byte 511
    extra_bytes = 1'b1;
    req_sector[31:0] = 32'h10;
    req = 2'b01;
    wait_grant("single_grant");
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_addr", sd_address, 32'h10);
    check("single_read_en", 32'(sd_read_en), 1);
    wait_done("single_done", 0);
    check("single_bytes", nbytes, 512);
    check("single_gnt_clr", 32'(gnt), 0);
    req = 2'b00;
    tick(12);
    check("single_done_once", done_cnt[0], 1);
    check("single_no_extra", nbytes, 512);
    check("single_one_grant", grant_cnt, 1);
    extra_bytes = 1'b0;

    // contention from reset, both held for four sectors
    do_reset();
    req_sector = {32'h200, 32'h100};
    g0 = grant_log.size();
    d0 = done_cnt[0] + done_cnt[1];
    req = 2'b11;
    begin
      int n = 0;
      while (done_cnt[0] + done_cnt[1] < d0 + 4 && n < 4000) begin tick(1); n++; end
    end
    req = 2'b00;
    check("cont_sectors", done_cnt[0] + done_cnt[1] - d0, 4);
    for (int i = 0; i < 4; i++) begin
      check("cont_order", (g0 + i < grant_log.size()) ? grant_log[g0 + i] : -1, i % 2);
      check("cont_addr", (g0 + i < addr_log.size()) ? addr_log[g0 + i] : 32'hFFFF_FFFF,
            (i % 2 == 0) ? 32'h100 : 32'h200);
    end

    // one sector for requester 0 moves the pointer to 1
    tick(2);
    req = 2'b01;
    wait_grant("pre_drop_grant");
    wait_done("pre_drop_done", 0);
    req = 2'b00;

    // requester 1 drops its request at byte 200
    tick(2);
    req_sector[63:32] = 32'h77;
    d0 = done_cnt[1];
    req = 2'b10;
    wait_grant("drop_grant");
    check("drop_gnt", 32'(gnt), 32'h2);
    check("drop_addr", sd_address, 32'h77);
    wait_bytes("drop_at200", 200);
    req = 2'b00;
    wait_done("drop_done", 1);
    check("drop_bytes", nbytes, 512);
    check("drop_done_cnt", done_cnt[1] - d0, 1);
    tick(2);
    req = 2'b11;
    wait_grant("drop_rr_grant");
    check("drop_rr_next", grant_log[grant_log.size() - 1], 0);
    wait_done("drop_rr_done", 0);
    req = 2'b00;

    // asynchronous reset in the middle of a transfer
    tick(2);
    req = 2'b01;
    wait_grant("mid_grant");
    wait_bytes("mid_at300", 300);
    reset = 1'b0;
    #1;
    check("mid_gnt", 32'(gnt), 0);
    check("mid_rd_valid", 32'(rd_valid), 0);
    check("mid_rd_index", 32'(rd_index), 0);
    check("mid_rd_data", 32'(rd_data), 0);
    check("mid_read_en", 32'(sd_read_en), 0);
    check("mid_address", sd_address, 0);
    wait_model_idle();
    tick(1);
    reset = 1'b1;
    wait_grant("mid_regrant");
    wait_bytes("mid_first", 1);
    check("mid_restart_idx", 32'(rd_index), 0);
    wait_done("mid_done", 0);
    check("mid_bytes", nbytes, 512);
    req = 2'b00;

    // watchdog: controller stalls after 100 bytes
    do_reset();
    stall_at = 100;
    d0 = done_cnt[0];
    req = 2'b01;
    wait_grant("wd_grant");
    gc = grant_cnt;
    begin
      int e0 = err_cnt[0];
      int n = 0;
      while (err_cnt[0] == e0 && n < TMO + 200) begin tick(1); n++; end
      check("wd_err_seen", 32'(err_cnt[0] != e0), 1);
    end
    check("wd_latency", err_cyc - grant_cyc, TMO);
    check("wd_bytes", nbytes, 100);
    check("wd_gnt", 32'(gnt), 0);
    check("wd_read_en", 32'(sd_read_en), 0);
    tick(20);
    check("wd_err_once", err_cnt[0], 1);
    check("wd_no_done", done_cnt[0] - d0, 0);
    wait_model_idle();
    stall_at = 100000;
    tick(30);
    check("wd_halt_grants", grant_cnt - gc, 0);
    check("wd_halt_read_en", 32'(sd_read_en), 0);
    req = 2'b00;

    check("protocol", proto_bad, 0);
    check("err1_never", err_cnt[1], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
